// File: rtl/rata_pkg.sv
// Shared definitions for the LMT (latest modification time) controller:
// FSM state encoding, LMT word offsets and the default address map.
package rata_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_UPD_LO    = 3'd1,
        ST_UPD_HI    = 3'd2,
        ST_VIOL_HOLD = 3'd3,
        ST_VIOL_WAIT = 3'd4
    } state_e;

    // Byte offsets of the two 32-bit LMT words relative to LMT_BASE.
    localparam logic [31:0] LMT_LO_OFS = 32'd0;
    localparam logic [31:0] LMT_HI_OFS = 32'd4;

    // Default address map.
    localparam logic [31:0] DEF_AR_BASE   = 32'h0000_E000;
    localparam logic [31:0] DEF_AR_END    = 32'h0000_FFFF;
    localparam logic [31:0] DEF_LMT_BASE  = 32'h0000_0140;
    localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
    localparam int unsigned DEF_RST_HOLD  = 16;

endpackage

// File: rtl/rata_addr_dec.sv
// Classifies one write port: attested-region hit and LMT-region hit.
module rata_addr_dec
    import rata_pkg::*;
#(
    parameter logic [31:0] AR_BASE  = DEF_AR_BASE,
    parameter logic [31:0] AR_END   = DEF_AR_END,
    parameter logic [31:0] LMT_BASE = DEF_LMT_BASE
) (
    input  logic        we,
    input  logic [31:0] addr,
    output logic        ar_hit,
    output logic        lmt_hit
);

    // LMT match ignores the byte offset inside the 8-byte region.
    always_comb begin
        ar_hit  = we && (addr >= AR_BASE) && (addr <= AR_END);
        lmt_hit = we && (addr[31:3] == LMT_BASE[31:3]);
    end

endmodule

// File: rtl/rata_lmt_ctrl.sv
// Stamps every attested-region write with a 64-bit timer value into the
// LMT words, and treats any direct write to the LMT region as a violation
// that requests a system reset and waits for the CPU to reach RESET_VEC.
module rata_lmt_ctrl
    import rata_pkg::*;
#(
    parameter logic [31:0] AR_BASE   = DEF_AR_BASE,
    parameter logic [31:0] AR_END    = DEF_AR_END,
    parameter logic [31:0] LMT_BASE  = DEF_LMT_BASE,
    parameter int unsigned RST_HOLD  = DEF_RST_HOLD,
    parameter logic [31:0] RESET_VEC = DEF_RESET_VEC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic        dma_we,
    input  logic [31:0] dma_addr,
    output logic        lmt_we,
    output logic        lmt_hi,
    output logic [31:0] lmt_wdata,
    output logic        sys_reset,
    output logic        busy,
    output logic [7:0]  viol_cnt,
    output state_e      dbg_state
);

    logic cpu_ar, cpu_lmt, dma_ar, dma_lmt;
    logic ar_hit, lmt_hit;

    state_e      state_q, state_d;
    logic [63:0] timer_q;
    logic [63:0] stamp_q, stamp_d;
    logic        pending_q, pending_d;
    logic [7:0]  hold_q, hold_d;
    logic        viol_inc;

    logic        lmt_we_d, lmt_hi_d, sys_reset_d, busy_d;
    logic [31:0] lmt_wdata_d;

    rata_addr_dec #(.AR_BASE(AR_BASE), .AR_END(AR_END), .LMT_BASE(LMT_BASE)) u_cpu_dec (
        .we(cpu_we), .addr(cpu_addr), .ar_hit(cpu_ar), .lmt_hit(cpu_lmt)
    );

    rata_addr_dec #(.AR_BASE(AR_BASE), .AR_END(AR_END), .LMT_BASE(LMT_BASE)) u_dma_dec (
        .we(dma_we), .addr(dma_addr), .ar_hit(dma_ar), .lmt_hit(dma_lmt)
    );

    assign ar_hit    = cpu_ar | dma_ar;
    assign lmt_hit   = cpu_lmt | dma_lmt;
    assign dbg_state = state_q;

    // Next-state logic; an LMT hit outranks any AR hit and aborts updates.
    always_comb begin
        state_d   = state_q;
        stamp_d   = stamp_q;
        pending_d = pending_q;
        hold_d    = hold_q;
        viol_inc  = 1'b0;
        case (state_q)
            ST_IDLE, ST_UPD_LO, ST_UPD_HI: begin
                if (lmt_hit) begin
                    state_d   = ST_VIOL_HOLD;
                    hold_d    = '0;
                    pending_d = 1'b0;
                    viol_inc  = 1'b1;
                end else if (state_q == ST_IDLE) begin
                    if (ar_hit || pending_q) begin
                        state_d   = ST_UPD_LO;
                        stamp_d   = timer_q;
                        pending_d = 1'b0;
                    end
                end else if (state_q == ST_UPD_LO) begin
                    state_d = ST_UPD_HI;
                    if (ar_hit) pending_d = 1'b1;
                end else if (pending_q) begin
                    // Fresh stamp covers every hit seen so far, including one now.
                    state_d   = ST_UPD_LO;
                    stamp_d   = timer_q;
                    pending_d = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                    if (ar_hit) pending_d = 1'b1;
                end
            end
            ST_VIOL_HOLD: begin
                if (hold_q == 8'(RST_HOLD - 1)) begin
                    state_d = ST_VIOL_WAIT;
                    hold_d  = '0;
                end else begin
                    hold_d = hold_q + 8'd1;
                end
            end
            ST_VIOL_WAIT: begin
                if (lmt_hit) begin
                    state_d  = ST_VIOL_HOLD;
                    hold_d   = '0;
                    viol_inc = 1'b1;
                end else if (pc == RESET_VEC) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output values for the coming cycle, derived from the next state.
    always_comb begin
        lmt_we_d    = (state_d == ST_UPD_LO) || (state_d == ST_UPD_HI);
        lmt_hi_d    = (state_d == ST_UPD_HI);
        lmt_wdata_d = '0;
        if (state_d == ST_UPD_LO) lmt_wdata_d = stamp_d[31:0];
        if (state_d == ST_UPD_HI) lmt_wdata_d = stamp_d[63:32];
        sys_reset_d = (state_d == ST_VIOL_HOLD);
        busy_d      = (state_d != ST_IDLE);
    end

    // State, timer, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            timer_q   <= '0;
            stamp_q   <= '0;
            pending_q <= 1'b0;
            hold_q    <= '0;
            viol_cnt  <= '0;
            lmt_we    <= 1'b0;
            lmt_hi    <= 1'b0;
            lmt_wdata <= '0;
            sys_reset <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_q + 64'd1;
            stamp_q   <= stamp_d;
            pending_q <= pending_d;
            hold_q    <= hold_d;
            if (viol_inc && (viol_cnt != 8'hFF)) viol_cnt <= viol_cnt + 8'd1;
            lmt_we    <= lmt_we_d;
            lmt_hi    <= lmt_hi_d;
            lmt_wdata <= lmt_wdata_d;
            sys_reset <= sys_reset_d;
            busy      <= busy_d;
        end
    end

endmodule

// File: tb/tb_rata_lmt_ctrl.sv
// Bench for rata_lmt_ctrl: directed scenarios plus a randomized run checked
// cycle by cycle against a behavioural model of the stamping/violation rules.
module tb_rata_lmt_ctrl;
    import rata_pkg::*;

    localparam logic [31:0] AR_BASE   = 32'h0000_E000;
    localparam logic [31:0] AR_END    = 32'h0000_FFFF;
    localparam logic [31:0] LMT_BASE  = 32'h0000_0140;
    localparam int          RST_HOLD  = 16;
    localparam logic [31:0] RESET_VEC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic        cpu_we, dma_we;
    logic [31:0] cpu_addr, dma_addr;
    logic        lmt_we, lmt_hi, sys_reset, busy;
    logic [31:0] lmt_wdata;
    logic [7:0]  viol_cnt;
    state_e      dbg_state;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model: phase 0 none / 1 low word / 2 high word.
    logic [63:0] m_timer, m_stamp;
    bit          m_pend, m_wait;
    int          m_phase, m_hold, m_viol;

    logic [32:0] exp_q[$];

    rata_lmt_ctrl #(
        .AR_BASE(AR_BASE), .AR_END(AR_END), .LMT_BASE(LMT_BASE),
        .RST_HOLD(RST_HOLD), .RESET_VEC(RESET_VEC)
    ) dut (
        .clk(clk), .rst(rst), .pc(pc),
        .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .dma_we(dma_we), .dma_addr(dma_addr),
        .lmt_we(lmt_we), .lmt_hi(lmt_hi), .lmt_wdata(lmt_wdata),
        .sys_reset(sys_reset), .busy(busy), .viol_cnt(viol_cnt),
        .dbg_state(dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic model_step();
        logic ar, lmt;
        if (rst) begin
            m_timer = '0; m_stamp = '0; m_pend = 0; m_wait = 0;
            m_phase = 0; m_hold = 0; m_viol = 0;
            return;
        end
        ar  = (cpu_we && cpu_addr >= AR_BASE && cpu_addr <= AR_END) ||
              (dma_we && dma_addr >= AR_BASE && dma_addr <= AR_END);
        lmt = (cpu_we && (cpu_addr & ~32'h7) == LMT_BASE) ||
              (dma_we && (dma_addr & ~32'h7) == LMT_BASE);
        if (m_hold > 0) begin
            m_hold--;
            if (m_hold == 0) m_wait = 1;
        end else if (m_wait) begin
            if (lmt) begin
                m_wait = 0; m_hold = RST_HOLD;
                if (m_viol < 255) m_viol++;
            end else if (pc == RESET_VEC) begin
                m_wait = 0;
            end
        end else if (lmt) begin
            m_phase = 0; m_pend = 0; m_hold = RST_HOLD;
            if (m_viol < 255) m_viol++;
        end else if (m_phase == 0) begin
            if (ar || m_pend) begin m_phase = 1; m_stamp = m_timer; m_pend = 0; end
        end else if (m_phase == 1) begin
            m_phase = 2;
            if (ar) m_pend = 1;
        end else begin
            if (m_pend) begin m_phase = 1; m_stamp = m_timer; m_pend = 0; end
            else begin m_phase = 0; if (ar) m_pend = 1; end
        end
        m_timer++;
    endtask

    function automatic logic [43:0] exp_vec();
        logic we, hi;
        logic [31:0] wd;
        we = (m_phase != 0);
        hi = (m_phase == 2);
        wd = !we ? 32'd0 : (hi ? m_stamp[63:32] : m_stamp[31:0]);
        return {we, hi, wd, (m_hold > 0), (m_phase != 0 || m_hold > 0 || m_wait), 8'(m_viol)};
    endfunction

    function automatic logic [43:0] obs_vec();
        return {lmt_we, lmt_hi, lmt_wdata, sys_reset, busy, viol_cnt};
    endfunction

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic drive_idle();
        cpu_we = 0; dma_we = 0; cpu_addr = '0; dma_addr = '0; pc = 32'h100;
    endtask

    task automatic do_reset();
        drive_idle();
        rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        cpu_we = 1; cpu_addr = 32'hE004; dma_we = 1; dma_addr = 32'h140; pc = $urandom;
        repeat (3) tick();
        n_cmp++;
        if (obs_vec() !== 44'd0) begin
            n_bad++; $display("FAIL reset_outputs: got %h want 0", obs_vec());
        end
        n_cmp++;
        if (dbg_state !== ST_IDLE) begin
            n_bad++; $display("FAIL reset_state: got %0d want %0d", dbg_state, ST_IDLE);
        end
        rst = 0;
        drive_idle();
    endtask

    task automatic test_single_update();
        do_reset();
        while (m_timer != 64'd100) tick();
        cpu_we = 1; cpu_addr = 32'hE010;
        tick();
        drive_idle();
        n_cmp++;
        if ({lmt_we, lmt_hi, lmt_wdata} !== {1'b1, 1'b0, 32'd100}) begin
            n_bad++; $display("FAIL single_lo: got %b %b %0d want 1 0 100", lmt_we, lmt_hi, lmt_wdata);
        end
        tick();
        n_cmp++;
        if ({lmt_we, lmt_hi, lmt_wdata} !== {1'b1, 1'b1, 32'd0}) begin
            n_bad++; $display("FAIL single_hi: got %b %b %0d want 1 1 0", lmt_we, lmt_hi, lmt_wdata);
        end
        tick();
        n_cmp++;
        if ({lmt_we, busy, lmt_wdata} !== {1'b0, 1'b0, 32'd0} || dbg_state !== ST_IDLE) begin
            n_bad++; $display("FAIL single_done: got we=%b busy=%b st=%0d want 0 0 IDLE", lmt_we, busy, dbg_state);
        end
    endtask

    task automatic test_coalesce();
        int we_cnt;
        logic [63:0] t2;
        do_reset();
        repeat (5) tick();
        cpu_we = 1; cpu_addr = 32'hE100;
        tick();
        we_cnt = int'(lmt_we);
        drive_idle();
        dma_we = 1; dma_addr = 32'hE800;
        tick();
        we_cnt += int'(lmt_we);
        t2 = m_timer;
        tick();
        we_cnt += int'(lmt_we);
        drive_idle();
        n_cmp++;
        if ({lmt_we, lmt_hi, lmt_wdata} !== {1'b1, 1'b0, t2[31:0]}) begin
            n_bad++; $display("FAIL coalesce_stamp: got %b %b %0d want 1 0 %0d", lmt_we, lmt_hi, lmt_wdata, t2[31:0]);
        end
        repeat (5) begin
            tick();
            we_cnt += int'(lmt_we);
        end
        n_cmp++;
        if (we_cnt != 4) begin
            n_bad++; $display("FAIL coalesce_count: got %0d want 4", we_cnt);
        end
    endtask

    task automatic test_viol_abort();
        int rst_cycles, we_seen;
        do_reset();
        cpu_we = 1; cpu_addr = 32'hE020;
        tick();
        cpu_addr = 32'h144;
        tick();
        drive_idle();
        n_cmp++;
        if ({lmt_we, sys_reset, viol_cnt} !== {1'b0, 1'b1, 8'd1}) begin
            n_bad++; $display("FAIL abort_entry: got we=%b rst=%b cnt=%0d want 0 1 1", lmt_we, sys_reset, viol_cnt);
        end
        rst_cycles = 1; we_seen = 0;
        repeat (25) begin
            tick();
            rst_cycles += int'(sys_reset);
            we_seen    += int'(lmt_we);
        end
        n_cmp++;
        if (rst_cycles != RST_HOLD || we_seen != 0) begin
            n_bad++; $display("FAIL abort_hold: got rst_cycles=%0d we=%0d want %0d 0", rst_cycles, we_seen, RST_HOLD);
        end
        pc = 32'h0;
        tick();
        n_cmp++;
        if (busy !== 1'b0 || dbg_state !== ST_IDLE) begin
            n_bad++; $display("FAIL abort_exit: got busy=%b st=%0d want 0 IDLE", busy, dbg_state);
        end
    endtask

    task automatic test_simultaneous();
        int we_seen;
        do_reset();
        cpu_we = 1; cpu_addr = 32'hE000; dma_we = 1; dma_addr = 32'h140;
        tick();
        drive_idle();
        we_seen = int'(lmt_we);
        n_cmp++;
        if ({sys_reset, viol_cnt} !== {1'b1, 8'd1}) begin
            n_bad++; $display("FAIL simul_viol: got rst=%b cnt=%0d want 1 1", sys_reset, viol_cnt);
        end
        repeat (20) begin
            tick();
            we_seen += int'(lmt_we);
        end
        n_cmp++;
        if (we_seen != 0) begin
            n_bad++; $display("FAIL simul_no_write: got %0d want 0", we_seen);
        end
        pc = 32'h0;
        tick();
    endtask

    task automatic test_viol_wait();
        int idle_seen;
        do_reset();
        cpu_we = 1; cpu_addr = 32'h140;
        tick();
        drive_idle();
        repeat (RST_HOLD) tick();
        n_cmp++;
        if ({sys_reset, busy} !== 2'b01) begin
            n_bad++; $display("FAIL wait_entry: got rst=%b busy=%b want 0 1", sys_reset, busy);
        end
        idle_seen = 0;
        repeat (50) begin
            tick();
            if (busy !== 1'b1) idle_seen++;
        end
        n_cmp++;
        if (idle_seen != 0) begin
            n_bad++; $display("FAIL wait_hold: got %0d idle cycles want 0", idle_seen);
        end
        pc = 32'h0;
        tick();
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++; $display("FAIL wait_exit: got busy=%b want 0", busy);
        end
        do_reset();
        for (int i = 0; i < 256; i++) begin
            cpu_we = 1; cpu_addr = 32'h140 + 32'($urandom_range(0, 7));
            tick();
            drive_idle();
            repeat (RST_HOLD) tick();
            if (i == 0 || i == 200) begin
                n_cmp++;
                if (viol_cnt !== 8'(i + 1)) begin
                    n_bad++; $display("FAIL sat_mid: got %0d want %0d", viol_cnt, i + 1);
                end
            end
        end
        n_cmp++;
        if (viol_cnt !== 8'd255) begin
            n_bad++; $display("FAIL sat_final: got %0d want 255", viol_cnt);
        end
        pc = 32'h0;
        tick();
    endtask

    task automatic test_rst_mid_update();
        do_reset();
        repeat (3) tick();
        cpu_we = 1; cpu_addr = 32'hFFF0;
        tick();
        drive_idle();
        n_cmp++;
        if (lmt_we !== 1'b1) begin
            n_bad++; $display("FAIL rmid_pre: got we=%b want 1", lmt_we);
        end
        rst = 1;
        tick();
        n_cmp++;
        if (obs_vec() !== 44'd0 || dbg_state !== ST_IDLE) begin
            n_bad++; $display("FAIL rmid_clear: got %h st=%0d want 0 IDLE", obs_vec(), dbg_state);
        end
        rst = 0;
        tick();
        n_cmp++;
        if ({lmt_we, busy} !== 2'b00) begin
            n_bad++; $display("FAIL rmid_no_partial: got we=%b busy=%b want 0 0", lmt_we, busy);
        end
        cpu_we = 1; cpu_addr = 32'hE000;
        tick();
        drive_idle();
        rst = 1;
        tick();
        rst = 0;
        cpu_we = 1; cpu_addr = 32'hE004;
        tick();
        drive_idle();
        n_cmp++;
        if ({lmt_we, lmt_hi, lmt_wdata} !== {1'b1, 1'b0, 32'd0}) begin
            n_bad++; $display("FAIL rmid_timer: got %b %b %0d want 1 0 0", lmt_we, lmt_hi, lmt_wdata);
        end
    endtask

    task automatic test_boundaries();
        logic [31:0] addrs [8];
        logic [1:0]  exps  [8];
        addrs = '{32'hDFFF, 32'hE000, 32'hFFFF, 32'h1_0000, 32'h13F, 32'h140, 32'h147, 32'h148};
        exps  = '{2'b00,    2'b10,    2'b10,    2'b00,      2'b00,   2'b01,   2'b01,   2'b00};
        for (int i = 0; i < 8; i++) begin
            do_reset();
            if (i % 2 == 0) begin cpu_we = 1; cpu_addr = addrs[i]; end
            else begin dma_we = 1; dma_addr = addrs[i]; end
            tick();
            drive_idle();
            n_cmp++;
            if ({lmt_we, sys_reset} !== exps[i]) begin
                n_bad++; $display("FAIL boundary_%h: got we/rst=%b want %b", addrs[i], {lmt_we, sys_reset}, exps[i]);
            end
        end
    endtask

    function automatic logic [31:0] pick_addr();
        int r;
        r = $urandom_range(0, 99);
        if (r < 50) return $urandom_range(32'hE000, 32'hFFFF);
        if (r < 53) return 32'h140 + 32'($urandom_range(0, 7));
        if (r < 70) begin
            case ($urandom_range(0, 5))
                0: return 32'hDFFF;
                1: return 32'hE000;
                2: return 32'hFFFF;
                3: return 32'h1_0000;
                4: return 32'h13F;
                default: return 32'h148;
            endcase
        end
        return $urandom;
    endfunction

    task automatic test_random();
        logic [43:0] e;
        logic [32:0] sb;
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            rst      = ($urandom_range(0, 399) == 0);
            cpu_we   = ($urandom_range(0, 3) == 0);
            cpu_addr = pick_addr();
            dma_we   = ($urandom_range(0, 4) == 0);
            dma_addr = pick_addr();
            pc       = ($urandom_range(0, 9) == 0) ? 32'h0 : $urandom;
            tick();
            e = exp_vec();
            if (e[43]) exp_q.push_back({e[42], e[41:10]});
            n_cmp++;
            if (obs_vec() !== e) begin
                n_bad++; $display("FAIL random_cycle_%0d: got %h want %h", i, obs_vec(), e);
            end
            if (lmt_we === 1'b1) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++; $display("FAIL random_sb_%0d: got unexpected LMT write %b %h", i, lmt_hi, lmt_wdata);
                end else begin
                    sb = exp_q.pop_front();
                    if ({lmt_hi, lmt_wdata} !== sb) begin
                        n_bad++; $display("FAIL random_sb_%0d: got %h want %h", i, {lmt_hi, lmt_wdata}, sb);
                    end
                end
            end
        end
        rst = 0;
        drive_idle();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++; $display("FAIL random_sb_drain: got %0d left want 0", exp_q.size());
        end
    endtask

    initial begin
        rst = 1;
        drive_idle();
        test_reset();
        test_single_update();
        test_coalesce();
        test_viol_abort();
        test_simultaneous();
        test_viol_wait();
        test_rst_mid_update();
        test_boundaries();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
